// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Multi-cycle subtractor computing diff = a - b - bin over
//                WIDTH bits, DIGIT bits per clock, LSB digit first, with the
//                inter-digit borrow held in a register. A start/busy/done
//                handshake frames each operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,   // operand/result width, >= 2
    parameter int DIGIT = 1    // bits per cycle, must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_brw;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT:0]     w_dig;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [WIDTH-1:0]   w_res_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

    // One digit of subtraction; the top bit of the DIGIT+1-bit result is the borrow
    assign w_dig = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_brw};

    // Operand shift and result assembly; a single-digit build has nothing left to shift
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_a_sh     = '0;
            assign w_b_sh     = '0;
            assign w_res_next = w_dig[DIGIT-1:0];
        end else begin : g_part
            assign w_a_sh     = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_sh     = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_res_next = {w_dig[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept only from IDLE, return to IDLE after the last digit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, one digit per RUN cycle, load results on the last digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_brw   <= bin;
                r_res   <= '0;
                r_cnt   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end else if (r_state == S_RUN) begin
                r_a   <= w_a_sh;
                r_b   <= w_b_sh;
                r_res <= w_res_next;
                r_brw <= w_dig[DIGIT];
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_diff <= w_res_next;
                    r_bout <= w_dig[DIGIT];
                    // Overflow uses the captured operand signs, not the live inputs
                    r_ovf  <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                    r_zero <= (w_res_next == '0);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed and randomised self-checking bench for
//                serial_subtractor in DIGIT=1, DIGIT=4 and DIGIT=8 builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DIGIT=1 instance
    logic       s1_start = 1'b0, s1_bin = 1'b0;
    logic [7:0] s1_a = '0, s1_b = '0;
    logic       s1_busy, s1_done, s1_bout, s1_ovf, s1_zero;
    logic [7:0] s1_diff;

    // DIGIT=4 instance
    logic       s4_start = 1'b0, s4_bin = 1'b0;
    logic [7:0] s4_a = '0, s4_b = '0;
    logic       s4_busy, s4_done, s4_bout, s4_ovf, s4_zero;
    logic [7:0] s4_diff;

    // DIGIT=8 instance
    logic       s8_start = 1'b0, s8_bin = 1'b0;
    logic [7:0] s8_a = '0, s8_b = '0;
    logic       s8_busy, s8_done, s8_bout, s8_ovf, s8_zero;
    logic [7:0] s8_diff;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bout(s1_bout), .ovf(s1_ovf), .zero(s1_zero)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b), .bin(s4_bin),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bout(s4_bout), .ovf(s4_ovf), .zero(s4_zero)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b), .bin(s8_bin),
        .busy(s8_busy), .done(s8_done), .diff(s8_diff), .bout(s8_bout), .ovf(s8_ovf), .zero(s8_zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one DIGIT=1 operation and wait (bounded) for done.
    // lat = edges from accept to done, bcyc = cycles observed with busy=1.
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int bcyc);
        s1_a = a; s1_b = b; s1_bin = bin; s1_start = 1'b1;
        tick;
        s1_start = 1'b0;
        lat = 0; bcyc = 0;
        while (s1_done !== 1'b1 && lat < 20) begin
            if (s1_busy === 1'b1) bcyc++;
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        n_checks++;
        if ({s1_busy, s1_done, s1_diff, s1_bout, s1_ovf, s1_zero} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, expected all 0",
                     s1_busy, s1_done, s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        n_checks++;
        if ({s4_busy, s4_done, s4_diff, s4_bout, s4_ovf, s4_zero} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut4: got busy=%b done=%b diff=%h, expected all 0", s4_busy, s4_done, s4_diff);
        end
        n_checks++;
        if ({s8_busy, s8_done, s8_diff, s8_bout, s8_ovf, s8_zero} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut8: got busy=%b done=%b diff=%h, expected all 0", s8_busy, s8_done, s8_diff);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int lat, bcyc;
        op1(8'h05, 8'h03, 1'b0, lat, bcyc);
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        n_checks++;
        if (bcyc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcyc); end
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero, s1_busy} !== {8'h02, 4'b0000}) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%h bout=%b ovf=%b zero=%b busy=%b expected 02 0 0 0 0",
                     s1_diff, s1_bout, s1_ovf, s1_zero, s1_busy);
        end
        tick;
        n_checks++;
        if (s1_done !== 1'b0 || s1_diff !== 8'h02) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b diff=%h expected 0 02", s1_done, s1_diff);
        end
    endtask

    task automatic test_borrow;
        int lat, bcyc;
        op1(8'h00, 8'h01, 1'b0, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'hFF, 3'b100}) begin
            n_fail++;
            $display("FAIL borrow_0_1: got diff=%h bout=%b ovf=%b zero=%b expected ff 1 0 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        op1(8'h10, 8'h10, 1'b1, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'hFF, 3'b100}) begin
            n_fail++;
            $display("FAIL borrow_bin: got diff=%h bout=%b ovf=%b zero=%b expected ff 1 0 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        op1(8'h10, 8'h0F, 1'b1, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h00, 3'b001}) begin
            n_fail++;
            $display("FAIL borrow_zero: got diff=%h bout=%b ovf=%b zero=%b expected 00 0 0 1", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        // 0 - max - 1 wraps to 0 with borrow out
        op1(8'h00, 8'hFF, 1'b1, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h00, 3'b101}) begin
            n_fail++;
            $display("FAIL borrow_wrap: got diff=%h bout=%b ovf=%b zero=%b expected 00 1 0 1", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
    endtask

    task automatic test_overflow;
        int lat, bcyc;
        op1(8'h80, 8'h01, 1'b0, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h7F, 3'b010}) begin
            n_fail++;
            $display("FAIL ovf_neg: got diff=%h bout=%b ovf=%b zero=%b expected 7f 0 1 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        op1(8'h7F, 8'hFF, 1'b0, lat, bcyc);
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h80, 3'b110}) begin
            n_fail++;
            $display("FAIL ovf_pos: got diff=%h bout=%b ovf=%b zero=%b expected 80 1 1 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
    endtask

    // Start during busy is ignored; start held in the done cycle is accepted on the next edge
    task automatic test_back_to_back;
        int dones, lat;
        s1_a = 8'h9C; s1_b = 8'h35; s1_bin = 1'b0; s1_start = 1'b1;
        tick;
        s1_start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin s1_start = 1'b1; s1_a = 8'h20; s1_b = 8'h01; end
            if (k == 5) begin s1_start = 1'b0; s1_a = 8'hFF; s1_b = 8'h00; s1_bin = 1'b1; end
            tick;
            if (s1_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 1 || s1_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_single_done: got dones=%0d done=%b expected 1 1", dones, s1_done);
        end
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h67, 3'b010}) begin
            n_fail++;
            $display("FAIL b2b_first_result: got diff=%h bout=%b ovf=%b zero=%b expected 67 0 1 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        s1_a = 8'h40; s1_b = 8'h11; s1_bin = 1'b0; s1_start = 1'b1;
        tick;
        s1_start = 1'b0;
        n_checks++;
        if (s1_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", s1_busy); end
        lat = 0;
        while (s1_done !== 1'b1 && lat < 20) begin tick; lat++; end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 8", lat); end
        n_checks++;
        if ({s1_diff, s1_bout, s1_ovf, s1_zero} !== {8'h2F, 3'b000}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got diff=%h bout=%b ovf=%b zero=%b expected 2f 0 0 0", s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        tick;
    endtask

    task automatic test_reset_midop;
        int dones, lat, bcyc;
        s1_a = 8'hAA; s1_b = 8'h01; s1_bin = 1'b0; s1_start = 1'b1;
        tick;
        s1_start = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        tick;
        n_checks++;
        if ({s1_busy, s1_done, s1_diff, s1_bout, s1_ovf, s1_zero} !== 13'h0) begin
            n_fail++;
            $display("FAIL midop_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b expected all 0",
                     s1_busy, s1_done, s1_diff, s1_bout, s1_ovf, s1_zero);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin tick; if (s1_done === 1'b1) dones++; end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL midop_no_done: got %0d done pulses expected 0", dones); end
        op1(8'h33, 8'h11, 1'b0, lat, bcyc);
        n_checks++;
        if (lat !== 8 || s1_diff !== 8'h22) begin
            n_fail++;
            $display("FAIL midop_restart: got lat=%0d diff=%h expected 8 22", lat, s1_diff);
        end
    endtask

    task automatic test_random_digit4;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] full;
        logic       eovf;
        int         lat;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            eovf = (ra[7] != rb[7]) && (full[7] != ra[7]);
            s4_a = ra; s4_b = rb; s4_bin = rbin; s4_start = 1'b1;
            tick;
            s4_start = 1'b0;
            lat = 0;
            while (s4_done !== 1'b1 && lat < 10) begin tick; lat++; end
            n_checks++;
            if (lat !== 2 || {s4_bout, s4_diff} !== full || s4_ovf !== eovf || s4_zero !== (full[7:0] == 8'h00)) begin
                n_fail++;
                $display("FAIL rand_d4 %h-%h-%b: got lat=%0d bout=%b diff=%h ovf=%b zero=%b expected 2 %b %h %b %b",
                         ra, rb, rbin, lat, s4_bout, s4_diff, s4_ovf, s4_zero, full[8], full[7:0], eovf, full[7:0] == 8'h00);
            end
        end
    endtask

    task automatic test_random_digit8;
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] full;
        logic       eovf;
        int         lat;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            eovf = (ra[7] != rb[7]) && (full[7] != ra[7]);
            s8_a = ra; s8_b = rb; s8_bin = rbin; s8_start = 1'b1;
            tick;
            s8_start = 1'b0;
            lat = 0;
            while (s8_done !== 1'b1 && lat < 10) begin tick; lat++; end
            n_checks++;
            if (lat !== 1 || {s8_bout, s8_diff} !== full || s8_ovf !== eovf || s8_zero !== (full[7:0] == 8'h00)) begin
                n_fail++;
                $display("FAIL rand_d8 %h-%h-%b: got lat=%0d bout=%b diff=%h ovf=%b zero=%b expected 1 %b %h %b %b",
                         ra, rb, rbin, lat, s8_bout, s8_diff, s8_ovf, s8_zero, full[8], full[7:0], eovf, full[7:0] == 8'h00);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_overflow;
        test_back_to_back;
        test_reset_midop;
        test_random_digit4;
        test_random_digit8;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
